dma_cmdq_ctrl: RTL
==================

// Module: dma_cmdq_ctrl
// PURPOSE
// - Per-direction DMA command front end: decodes MMIO64 writes at the host-rd (0x10) or host-wr (0x20) base, stages
//   src/dst, pushes {src,dst,len} into a 16-deep command queue on length write, presents head to the data-mover.
// - Tracks in-flight commands, raises done IRQ, serves CMDQ_STATUS/CONFIG/STATUS reads. One instance per direction.
// PARAMETERS
// - BASE_ADDR   'h10                       register base (REG_HOSTRD_BASE_ADDR or REG_HOSTWR_BASE_ADDR)
// - SRC_AW      HOST_MEM_ADDR_WIDTH        source address width
// - DST_AW      DEVICE_MEM_ADDR_WIDTH      destination address width
// - DEPTH       CMDQ_DEPTH (16)            queue entries, power of two, <= 2**CMDQ_USEDW_WIDTH-1
// PORTS
// - clk              in   1        single clock
// - reset_n          in   1        synchronous, active-low reset
// - mmio_wr          in   1        MMIO64 write strobe
// - mmio_rd          in   1        MMIO64 read strobe
// - mmio_addr        in   8        MMIO64 qword address (MMIO64_ADDR_WIDTH)
// - mmio_wrdata      in   64       write data
// - mmio_rddata      out  64       read data
// - mmio_rdvalid     out  1        read data valid, exactly 1 cycle after mmio_rd when address hits this block
// - cmd_valid        out  1        queue head valid
// - cmd_ready        in   1        data-mover accepts head
// - cmd_src/dst/len  out  SRC_AW/DST_AW/40   head fields
// - xfer_done        in   1        one-cycle pulse: data-mover finished one command
// - irq              out  1        sticky completion interrupt
// BEHAVIOUR
// - Reset: all outputs 0, queue empty, staging regs 0, inflight=0, overflow=0, irq=0; mmio_rddata=0.
// - Write BASE+0/+1: load src_stage/dst_stage (low SRC_AW/DST_AW bits). Write BASE+2: if len[39:0]!=0 and
//   !full, push {src_stage,dst_stage,len}; if full, drop and set overflow sticky; len==0 dropped silently.
// - Full decided on registered count: push while full rejected even with same-cycle pop.
// - Pop when cmd_valid&&cmd_ready; inflight++ on pop, inflight-- on xfer_done; both same cycle -> unchanged.
//   xfer_done with inflight==0 ignored (no underflow).
// - Head fields stable while cmd_valid&&!cmd_ready; queue is show-ahead, push-to-cmd_valid latency 1 cycle.
// - irq set on xfer_done when queue empty and inflight becomes 0; irq holds until cleared.
// - Write BASE+5 (CONFIG): bit CONFIG_REG_SCLR_BIT flushes queue, staging, inflight, overflow, irq next cycle
//   (clear wins over same-cycle push/pop); bit CONFIG_REG_CLEAR_IRQ_BIT clears irq (set wins if same cycle).
// - Reads (1-cycle latency): BASE+0/1 staging; +2 last written len; +3 CMDQ_STATUS {54'0,overflow,full,count[7:0]};
//   +5 CONFIG reads 0; +6 STATUS bit0 busy (count!=0||inflight!=0), bit2 irq; other BASE+0..F -> REG_RD_BADADDR_DATA.
//   Address outside BASE..BASE+F: no rdvalid.
// - Reset mid-operation: everything returns to reset values, in-flight xfer_done pulses afterwards ignored.
// STRUCTURE
// - dma_pkg: addresses, CONFIG/STATUS bit positions, CMDQ_DEPTH, CMDQ_USEDW_WIDTH; add typedef
//   dma_cmd_t {src,dst,len} and CMDQ_STATUS_OVERFLOW_BIT=9, CMDQ_STATUS_FULL_BIT=8.
// - Sub-module dma_cmdq_fifo: show-ahead register-array FIFO of dma_cmd_t with sclr, count, full/empty.
// - Top: MMIO decode, staging regs, inflight counter (CMDQ_USEDW_WIDTH bits), irq/overflow flops, read mux.
// TESTING
// - Write src=0x1000,dst=0x40,len=0x200 -> cycle+1 cmd_valid=1 with those fields; CMDQ_STATUS count=1.
// - 17 length writes, cmd_ready=0 -> count=16, full=1, overflow=1; 17th lost; drain yields first 16 in order.
// - Pop 2, pulse xfer_done twice -> STATUS busy=0, irq=1 after 2nd pulse; CONFIG write 0x2 -> irq=0.
// - Push+pop same cycle at count=3 -> count stays 3; push at full with pop -> count 15, overflow=1.
// - CONFIG write 0x1 with 5 queued, 2 in flight -> count=0, busy=0, cmd_valid=0; later xfer_done ignored, irq=0.
// - Read BASE+9 -> 0x0BAD0ADD0BAD0ADD; read 0x40 -> no mmio_rdvalid; reset_n low mid-drain -> all outputs 0.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared definitions for the DMA command-queue front end:
//            register map, bit positions, queue sizing, command record type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int HOST_MEM_ADDR_WIDTH   = 48;
  localparam int DEVICE_MEM_ADDR_WIDTH = 32;
  localparam int CMDQ_LEN_WIDTH        = 40;
  localparam int MMIO64_ADDR_WIDTH     = 8;

  localparam logic [MMIO64_ADDR_WIDTH-1:0] REG_HOSTRD_BASE_ADDR = 8'h10;
  localparam logic [MMIO64_ADDR_WIDTH-1:0] REG_HOSTWR_BASE_ADDR = 8'h20;

  // Register offsets inside the 16-qword window of one direction
  localparam logic [3:0] REG_OFS_SRC         = 4'h0;
  localparam logic [3:0] REG_OFS_DST         = 4'h1;
  localparam logic [3:0] REG_OFS_LEN         = 4'h2;
  localparam logic [3:0] REG_OFS_CMDQ_STATUS = 4'h3;
  localparam logic [3:0] REG_OFS_CONFIG      = 4'h5;
  localparam logic [3:0] REG_OFS_STATUS      = 4'h6;

  localparam int CONFIG_REG_SCLR_BIT      = 0;
  localparam int CONFIG_REG_CLEAR_IRQ_BIT = 1;
  localparam int STATUS_REG_BUSY_BIT      = 0;
  localparam int STATUS_REG_IRQ_BIT       = 2;

  localparam int CMDQ_STATUS_FULL_BIT     = 8;
  localparam int CMDQ_STATUS_OVERFLOW_BIT = 9;

  localparam int CMDQ_DEPTH       = 16;
  localparam int CMDQ_USEDW_WIDTH = 8;

  localparam logic [63:0] REG_RD_BADADDR_DATA = 64'h0BAD_0ADD_0BAD_0ADD;

  typedef struct packed {
    logic [HOST_MEM_ADDR_WIDTH-1:0]   src;
    logic [DEVICE_MEM_ADDR_WIDTH-1:0] dst;
    logic [CMDQ_LEN_WIDTH-1:0]        len;
  } dma_cmd_t;

endpackage
`default_nettype wire

// File: rtl/dma_cmdq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_cmdq_fifo
// Purpose  : Show-ahead register-array FIFO of dma_cmd_t. The head entry is
//            visible on 'head' whenever 'empty' is low; 'pop' consumes it.
// Ports    : clk, reset_n (sync, active-low), sclr (sync flush, wins over
//            push/pop), push/push_data, pop, head, count, full, empty.
//            Push while full and pop while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dma_cmdq_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = CMDQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sclr,
  input  logic                     push,
  input  dma_cmd_t                 push_data,
  input  logic                     pop,
  output dma_cmd_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_PW = $clog2(DEPTH);

  dma_cmd_t        r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == (c_PW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n || sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PW+1)'(1);
        2'b01:   r_count <= r_count - (c_PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale entries are never visible because the
  // consumer qualifies the head with !empty.
  always_ff @(posedge clk) begin
    if (reset_n && !sclr && w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_cmdq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_cmdq_ctrl
// Purpose  : Per-direction DMA command front end. Decodes MMIO64 writes in
//            the BASE_ADDR..BASE_ADDR+15 window, stages src/dst, pushes a
//            {src,dst,len} command on each non-zero length write, presents
//            the queue head to the data-mover, tracks in-flight commands,
//            raises a sticky completion irq and serves register reads.
// Ports    : clk, reset_n (sync, active-low)
//            mmio_wr/mmio_rd/mmio_addr/mmio_wrdata  - MMIO64 request
//            mmio_rddata/mmio_rdvalid               - read reply (1 cycle)
//            cmd_valid/cmd_ready/cmd_src/dst/len    - head to data-mover
//            xfer_done                              - one command finished
//            irq                                    - sticky completion irq
// Revision : 1.0 - initial release
// ============================================================================
module dma_cmdq_ctrl
  import dma_pkg::*;
#(
  parameter logic [MMIO64_ADDR_WIDTH-1:0] BASE_ADDR = REG_HOSTRD_BASE_ADDR,
  parameter int SRC_AW = HOST_MEM_ADDR_WIDTH,
  parameter int DST_AW = DEVICE_MEM_ADDR_WIDTH,
  parameter int DEPTH  = CMDQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mmio_wr,
  input  logic                          mmio_rd,
  input  logic [MMIO64_ADDR_WIDTH-1:0]  mmio_addr,
  input  logic [63:0]                   mmio_wrdata,
  output logic [63:0]                   mmio_rddata,
  output logic                          mmio_rdvalid,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [SRC_AW-1:0]             cmd_src,
  output logic [DST_AW-1:0]             cmd_dst,
  output logic [CMDQ_LEN_WIDTH-1:0]     cmd_len,
  input  logic                          xfer_done,
  output logic                          irq
);

  localparam int c_CW = $clog2(DEPTH) + 1;

  // --------------------------------------------------------------------------
  // Address decode: offset computed one bit wider so addresses below the base
  // wrap to large values and fall outside the window.
  // --------------------------------------------------------------------------
  logic [MMIO64_ADDR_WIDTH:0] w_addr_diff;
  logic [3:0]                 w_ofs;
  logic                       w_hit;

  assign w_addr_diff = {1'b0, mmio_addr} - {1'b0, BASE_ADDR};
  assign w_hit       = (w_addr_diff < (MMIO64_ADDR_WIDTH+1)'(16));
  assign w_ofs       = w_addr_diff[3:0];

  logic w_wr_src, w_wr_dst, w_wr_len, w_wr_cfg, w_rd_hit;
  assign w_wr_src = mmio_wr && w_hit && (w_ofs == REG_OFS_SRC);
  assign w_wr_dst = mmio_wr && w_hit && (w_ofs == REG_OFS_DST);
  assign w_wr_len = mmio_wr && w_hit && (w_ofs == REG_OFS_LEN);
  assign w_wr_cfg = mmio_wr && w_hit && (w_ofs == REG_OFS_CONFIG);
  assign w_rd_hit = mmio_rd && w_hit;

  logic w_sclr, w_clr_irq;
  assign w_sclr    = w_wr_cfg && mmio_wrdata[CONFIG_REG_SCLR_BIT];
  assign w_clr_irq = w_wr_cfg && mmio_wrdata[CONFIG_REG_CLEAR_IRQ_BIT];

  // --------------------------------------------------------------------------
  // Staging and last-length registers
  // --------------------------------------------------------------------------
  logic [SRC_AW-1:0] r_src_stage;
  logic [DST_AW-1:0] r_dst_stage;
  logic [63:0]       r_last_len;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src_stage <= '0;
      r_dst_stage <= '0;
      r_last_len  <= '0;
    end else begin
      if (w_sclr) begin
        r_src_stage <= '0;
        r_dst_stage <= '0;
      end else begin
        if (w_wr_src) r_src_stage <= mmio_wrdata[SRC_AW-1:0];
        if (w_wr_dst) r_dst_stage <= mmio_wrdata[DST_AW-1:0];
      end
      if (w_wr_len) r_last_len <= mmio_wrdata;
    end
  end

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  dma_cmd_t        w_push_cmd;
  dma_cmd_t        w_head;
  logic [c_CW-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf_set;

  assign w_push_cmd.src = HOST_MEM_ADDR_WIDTH'(r_src_stage);
  assign w_push_cmd.dst = DEVICE_MEM_ADDR_WIDTH'(r_dst_stage);
  assign w_push_cmd.len = mmio_wrdata[CMDQ_LEN_WIDTH-1:0];

  // Full is the registered flag: a push at full is dropped even if the head
  // is being popped in the same cycle.
  assign w_push_req = w_wr_len && (mmio_wrdata[CMDQ_LEN_WIDTH-1:0] != '0);
  assign w_push     = w_push_req && !w_full;
  assign w_ovf_set  = w_push_req && w_full;
  assign w_pop      = !w_empty && cmd_ready;

  dma_cmdq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclr      (w_sclr),
    .push      (w_push),
    .push_data (w_push_cmd),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign cmd_valid = !w_empty;
  assign cmd_src   = cmd_valid ? w_head.src[SRC_AW-1:0] : '0;
  assign cmd_dst   = cmd_valid ? w_head.dst[DST_AW-1:0] : '0;
  assign cmd_len   = cmd_valid ? w_head.len             : '0;

  // --------------------------------------------------------------------------
  // In-flight tracking, irq and overflow
  // --------------------------------------------------------------------------
  logic [CMDQ_USEDW_WIDTH-1:0] r_inflight;
  logic                        r_irq;
  logic                        r_overflow;
  logic                        w_done_ok;
  logic                        w_irq_set;

  assign w_done_ok = xfer_done && (r_inflight != '0);
  // Last outstanding command finishing with nothing queued. A pop cannot
  // coincide because it needs a non-empty queue.
  assign w_irq_set = w_done_ok && (r_inflight == CMDQ_USEDW_WIDTH'(1)) && w_empty;

  always_ff @(posedge clk) begin
    if (!reset_n || w_sclr) begin
      r_inflight <= '0;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_pop, w_done_ok})
        2'b10:   r_inflight <= r_inflight + CMDQ_USEDW_WIDTH'(1);
        2'b01:   r_inflight <= r_inflight - CMDQ_USEDW_WIDTH'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_irq_set)      r_irq <= 1'b1;
      else if (w_clr_irq) r_irq <= 1'b0;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign irq = r_irq;

  // --------------------------------------------------------------------------
  // Read mux and registered reply
  // --------------------------------------------------------------------------
  logic [63:0] w_rd_mux;
  logic [63:0] r_rddata;
  logic        r_rdvalid;

  always_comb begin
    w_rd_mux = '0;
    case (w_ofs)
      REG_OFS_SRC: w_rd_mux[SRC_AW-1:0] = r_src_stage;
      REG_OFS_DST: w_rd_mux[DST_AW-1:0] = r_dst_stage;
      REG_OFS_LEN: w_rd_mux = r_last_len;
      REG_OFS_CMDQ_STATUS: begin
        w_rd_mux[7:0]                      = 8'(w_count);
        w_rd_mux[CMDQ_STATUS_FULL_BIT]     = w_full;
        w_rd_mux[CMDQ_STATUS_OVERFLOW_BIT] = r_overflow;
      end
      REG_OFS_CONFIG: w_rd_mux = '0;
      REG_OFS_STATUS: begin
        w_rd_mux[STATUS_REG_BUSY_BIT] = !w_empty || (r_inflight != '0);
        w_rd_mux[STATUS_REG_IRQ_BIT]  = r_irq;
      end
      default: w_rd_mux = REG_RD_BADADDR_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdvalid <= 1'b0;
      r_rddata  <= '0;
    end else begin
      r_rdvalid <= w_rd_hit;
      r_rddata  <= w_rd_hit ? w_rd_mux : '0;
    end
  end

  assign mmio_rdvalid = r_rdvalid;
  assign mmio_rddata  = r_rddata;

endmodule
`default_nettype wire
